// File: rtl/bitty_program_loader.sv
// Program loader: accepts a length-prefixed byte stream and writes it into instruction memory
// while holding the core in reset. Build option: LOADER_CHECKSUM_EN adds a trailing checksum byte.
module bitty_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-1:0] last_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                we_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                hold_d, done_d, err_d;
  logic [ADDR_W-1:0]   last_d;
  logic                accept;
  logic [DATA_W-1:0]   len_high;
  logic                oversize;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  // A length byte is oversize when any bit above the address width is set.
  assign len_high = in_data >> ADDR_W;
  assign oversize = |len_high;
  assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = mem_addr;
    wdata_d = mem_wdata;
    hold_d  = core_hold;
    done_d  = load_done;
    err_d   = load_error;
    last_d  = last_addr;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          if (oversize) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            len_d   = in_data[ADDR_W-1:0];
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = in_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + in_data;
`endif
          if (cnt_q == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
            last_d  = len_q;
            hold_d  = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            last_d  = len_q;
            hold_d  = 1'b0;
          end else begin
            // Core stays held so a corrupt image can never start executing.
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      last_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      mem_we     <= we_d;
      mem_addr   <= waddr_d;
      mem_wdata  <= wdata_d;
      core_hold  <= hold_d;
      load_done  <= done_d;
      load_error <= err_d;
      last_addr  <= last_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_bitty_program_loader.sv
// Scoreboard bench for bitty_program_loader (ADDR_W=4): expected memory writes are queued by
// the stimulus and popped by a monitor whenever mem_we is seen.
module tb_bitty_program_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;
  logic [AW-1:0] last_addr;

  bitty_program_loader #(.ADDR_W(AW), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .last_addr  (last_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  exp_addr = 0;
  logic [7:0] sum;

  // Monitor: every observed write must match the oldest expected write, in the cycle after acceptance.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL write actual addr=%0h data=%0h cyc=%0d required addr=%0h data=%0h cyc=%0d",
                   mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; data bytes queue an expected write at the next address.
  task automatic send(input logic [7:0] b, input bit is_data, input int gap);
    wr_t w;
    bit  ok;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        if (is_data) begin
          w.addr = exp_addr[AW-1:0];
          w.data = b;
          w.cyc  = cyc;
          exp_q.push_back(w);
          exp_addr++;
        end
      end else begin
        tick();
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout byte=%0h not accepted within 50 cycles", b);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with random activity on the inputs.
    reset = 1'b0;
    repeat (2) begin
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      tick();
    end
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_core_hold", 32'(core_hold), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_error", 32'(load_error), 0);
    check("rst_last_addr", 32'(last_addr), 0);
    start = 1'b0;
    in_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Basic three-word load.
    pulse_start();
    check("t1_hold_after_start", 32'(core_hold), 1);
    check("t1_ready_in_len", 32'(in_ready), 1);
    exp_addr = 0;
    send(8'h02, 0, 0);
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    send(8'h33, 1, 0);
`ifdef LOADER_CHECKSUM_EN
    check("t1_hold_before_csum", 32'(core_hold), 1);
    send(8'h66, 0, 0);
`endif
    check("t1_done", 32'(load_done), 1);
    check("t1_last_addr", 32'(last_addr), 2);
    check("t1_hold", 32'(core_hold), 0);
    check("t1_error", 32'(load_error), 0);
    check("t1_ready_idle", 32'(in_ready), 0);
    tick();

`ifdef LOADER_CHECKSUM_EN
    // Checksum mismatch, then recovery.
    pulse_start();
    exp_addr = 0;
    send(8'h02, 0, 0);
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    send(8'h33, 1, 0);
    send(8'h65, 0, 0);
    check("t2_error", 32'(load_error), 1);
    check("t2_done", 32'(load_done), 0);
    check("t2_hold", 32'(core_hold), 1);
    pulse_start();
    check("t2_error_cleared", 32'(load_error), 0);
    exp_addr = 0;
    send(8'h02, 0, 0);
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    send(8'h33, 1, 0);
    send(8'h66, 0, 0);
    check("t2_recover_done", 32'(load_done), 1);
    check("t2_recover_hold", 32'(core_hold), 0);
`endif

    // Oversize length, then full-depth load ending at the all-ones address.
    pulse_start();
    send(8'h10, 0, 0);
    check("t3_error", 32'(load_error), 1);
    check("t3_hold", 32'(core_hold), 1);
    check("t3_done", 32'(load_done), 0);
    check("t3_ready_err", 32'(in_ready), 0);
    tick();
    tick();
    pulse_start();
    check("t3_error_cleared", 32'(load_error), 0);
    check("t3_hold_restart", 32'(core_hold), 1);
    exp_addr = 0;
    sum = 8'h00;
    send(8'h0F, 0, 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(8'h80 + i * 7);
      sum = sum + b;
      send(b, 1, 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send(sum, 0, 0);
`endif
    check("t3_done_full", 32'(load_done), 1);
    check("t3_last_addr_full", 32'(last_addr), 32'hF);
    check("t3_hold_full", 32'(core_hold), 0);

    // Stalls and ignored start pulses mid-load.
    pulse_start();
    exp_addr = 0;
    send(8'h03, 0, 0);
    send(8'hA1, 1, 2);
    pulse_start();
    send(8'hB2, 1, 1);
    start = 1'b1;
    send(8'hC3, 1, 0);
    start = 1'b0;
    send(8'hD4, 1, 3);
`ifdef LOADER_CHECKSUM_EN
    send(8'hEA, 0, 1);
`endif
    check("t4_done", 32'(load_done), 1);
    check("t4_last_addr", 32'(last_addr), 3);
    check("t4_error", 32'(load_error), 0);

    // Start together with in_valid in IDLE, then reset after the second data byte.
    in_valid = 1'b1;
    in_data  = 8'h01;
    check("t5_ready_idle", 32'(in_ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("t5_reload_done_clr", 32'(load_done), 0);
    check("t5_reload_hold", 32'(core_hold), 1);
    check("t5_in_len", 32'(in_ready), 1);
    exp_addr = 0;
    send(8'h04, 0, 0);
    send(8'hA0, 1, 0);
    send(8'hA1, 1, 1);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    tick();
    check("t5_rst_hold", 32'(core_hold), 0);
    check("t5_rst_we", 32'(mem_we), 0);
    check("t5_rst_ready", 32'(in_ready), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("t5_after_rst_hold", 32'(core_hold), 0);
    check("t5_after_rst_done", 32'(load_done), 0);

    // Single-word program; the following byte must not be taken.
    pulse_start();
    exp_addr = 0;
    send(8'h00, 0, 0);
    send(8'hAB, 1, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'hAB, 0, 0);
`endif
    check("t6_done", 32'(load_done), 1);
    check("t6_last_addr", 32'(last_addr), 0);
    check("t6_hold", 32'(core_hold), 0);
    in_valid = 1'b1;
    in_data  = 8'hCD;
    check("t6_ready_after", 32'(in_ready), 0);
    tick();
    tick();
    in_valid = 1'b0;
    check("t6_done_held", 32'(load_done), 1);

    repeat (3) tick();
    check("writes_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bitty_program_loader.md
Name: bitty_program_loader

Overview:
- Write-side counterpart of the instruction fetch path. It receives a program as a byte stream over a valid/ready handshake and writes it into the instruction memory that the fetch unit reads.
- It holds the fetch unit and the core in reset while loading.
- It reports success, or a length or checksum error, to the top level.

Parameters:
- ADDR_W, 8, instruction memory address width. Depth is 2^ADDR_W. Legal range 1..8.
- DATA_W, 8, instruction/stream byte width. Fixed at 8; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or ERROR
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte
- mem_we  output  1  instruction memory write enable
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  8  write data
- core_hold  output  1  drives fetch unit/core reset; 1 = hold
- load_done  output  1  level; last load completed successfully
- load_error  output  1  level; last load failed
- last_addr  output  ADDR_W  address of the final instruction written; valid while load_done=1

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; all outputs 0; internal counter and checksum 0.
- Transfer occurs on a clk edge where in_valid && in_ready. in_ready is combinational from state only: 1 in LEN, DATA, CHECK; 0 elsewhere.
- States and transitions:
  - IDLE/ERROR: start=1 → LEN. On that edge, clear load_done, load_error and the checksum, and set core_hold=1.
  - LEN: accepted byte L.
    - If L > 2^ADDR_W-1 → ERROR.
    - Otherwise store L, set addr counter=0 → DATA.
    - Word count N = L+1, so 1..2^ADDR_W words; no zero-length programs.
  - DATA: each accepted byte is written to the current counter address. Checksum += byte, mod 256.
    - When counter == L → CHECK; otherwise counter+1.
  - CHECK: accepted byte compared with the checksum.
    - Equal → IDLE: load_done=1, last_addr=L, core_hold=0.
    - Unequal → ERROR: load_error=1, core_hold stays 1.
- Write timing: mem_we, mem_addr and mem_wdata are registered. mem_we=1 exactly the cycle after each accepted DATA byte, with that byte's address and data. Write latency is 1 cycle.
- No write occurs for LEN or CHECK bytes, or while in_valid=0.
- Stalls: in_valid=0 holds state indefinitely; there is no timeout.
- start in LEN/DATA/CHECK is ignored.
- start in IDLE after a successful load reloads: load_done clears, core_hold rises.
- core_hold:
  - 0 in IDLE.
  - 1 from the start edge through the final CHECK byte edge.
  - Stays 1 in ERROR until the next successful load or reset.
- Reset mid-load aborts immediately: core_hold=0, no further writes. Memory contents already written are left as is.
- Simultaneous start and in_valid in IDLE: only start acts; the byte is not accepted because in_ready=0.
- Counter wrap: with L=2^ADDR_W-1 the last address is all-ones. The counter never increments past L.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: the CHECK state and checksum compare operate as above.
- Undefined:
  - No CHECK state and no checksum byte is consumed.
  - The edge accepting the byte at counter == L goes directly to IDLE with load_done=1, last_addr=L, core_hold=0.
  - load_error is raised only by an oversize length.

Test Plan:
- reset=0 for 2 cycles with random in_valid/start → all outputs 0; no mem_we.
- start, then stream 0x02, 0x11, 0x22, 0x33, checksum 0x66 → writes (0,0x11), (1,0x22), (2,0x33), each one cycle after acceptance. Then load_done=1, last_addr=2, core_hold=0.
- Same stream with checksum 0x65 → three writes occur, then load_error=1, load_done=0, core_hold stays 1. A further start followed by a valid stream recovers.
- ADDR_W=4, length byte 0x10 → ERROR with no writes. Length 0x0F with 16 bytes → last write at address 0xF, load_done=1.
- Random in_valid gaps during DATA plus start pulses mid-load → writes unchanged and start ignored. Asserting reset after the 2nd data byte → core_hold=0, no further mem_we.
- LOADER_CHECKSUM_EN undefined, stream 0x00, 0xAB → single write (0,0xAB), then load_done=1 on that edge. The next byte is not accepted (in_ready=0).
